// File: rtl/spatz_retire_unit.sv
// spatz_retire_unit
//   Collects completion responses from VFU, VLSU and VSLDU and produces:
//     - a registered one-cycle vreg release mask and instruction-ID retire mask
//     - an in-order ready/valid scalar response stream toward the core
//       (VFU rd writebacks and VLSU exceptions), buffered in a small FIFO.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   vfu_rsp_valid_i/_i/_ready_o         VFU completion handshake + payload
//   vlsu_rsp_valid_i/_i/_ready_o        VLSU completion handshake + payload
//   vsldu_rsp_valid_i/_i/_ready_o       VSLDU completion handshake + payload
//   retire_vreg_o [NRVREG]              registers released (one-cycle pulse)
//   retire_id_o   [32]                  instruction IDs retired (one-cycle pulse)
//   rsp_valid_o / rsp_ready_i           core response handshake
//   rsp_id_o, rsp_rd_o, rsp_result_o, rsp_exc_o   core response payload

package spatz_retire_pkg;
   localparam int unsigned NRVREG = 32;
   localparam int unsigned ELEN   = 32;

   typedef logic [4:0]                instr_id_t;
   typedef logic [$clog2(NRVREG)-1:0] vreg_t;

   typedef struct packed {
      instr_id_t       id;
      vreg_t           vd;
      vreg_t           vs1;
      vreg_t           vs2;
      logic            wb;
      logic [4:0]      rd;
      logic [ELEN-1:0] result;
   } vfu_rsp_t;

   typedef struct packed {
      instr_id_t id;
      vreg_t     vd;
      logic      exc;
   } vlsu_rsp_t;

   typedef struct packed {
      instr_id_t id;
      vreg_t     vd;
      vreg_t     vs2;
   } vsldu_rsp_t;

   typedef struct packed {
      instr_id_t       id;
      logic [4:0]      rd;
      logic [ELEN-1:0] result;
      logic            exc;
   } core_rsp_t;
endpackage

module spatz_retire_unit
   import spatz_retire_pkg::*;
#(
   parameter int unsigned NrWbEntries = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              vfu_rsp_valid_i,
   input  vfu_rsp_t          vfu_rsp_i,
   output logic              vfu_rsp_ready_o,
   input  logic              vlsu_rsp_valid_i,
   input  vlsu_rsp_t         vlsu_rsp_i,
   output logic              vlsu_rsp_ready_o,
   input  logic              vsldu_rsp_valid_i,
   input  vsldu_rsp_t        vsldu_rsp_i,
   output logic              vsldu_rsp_ready_o,
   output logic [NRVREG-1:0] retire_vreg_o,
   output logic [31:0]       retire_id_o,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [4:0]        rsp_id_o,
   output logic [4:0]        rsp_rd_o,
   output logic [ELEN-1:0]   rsp_result_o,
   output logic              rsp_exc_o
);

   localparam int unsigned PtrW = (NrWbEntries > 1) ? $clog2(NrWbEntries) : 1;
   localparam int unsigned CntW = $clog2(NrWbEntries + 1);

   typedef logic [PtrW-1:0] ptr_t;

   core_rsp_t         mem [NrWbEntries];
   ptr_t              wptr, rptr;
   logic [CntW-1:0]   cnt;
   logic              full, empty, pop, push, space;
   logic              vfu_acc, vlsu_acc, vsldu_acc;
   core_rsp_t         push_entry, head;
   logic [NRVREG-1:0] vreg_d;
   logic [31:0]       id_d;

   assign full  = (cnt == CntW'(NrWbEntries));
   assign empty = (cnt == '0);
   assign pop   = rsp_valid_o && rsp_ready_i;
   // A pop this cycle frees a slot, so a full FIFO still takes a push.
   assign space = !full || pop;

   // Readies depend on the payload's FIFO need, not on valid.
   assign vfu_rsp_ready_o   = vfu_rsp_i.wb ? space : 1'b1;
   assign vlsu_rsp_ready_o  = vlsu_rsp_i.exc ? (space && !(vfu_rsp_valid_i && vfu_rsp_i.wb)) : 1'b1;
   assign vsldu_rsp_ready_o = 1'b1;

   assign vfu_acc   = vfu_rsp_valid_i && vfu_rsp_ready_o;
   assign vlsu_acc  = vlsu_rsp_valid_i && vlsu_rsp_ready_o;
   assign vsldu_acc = vsldu_rsp_valid_i && vsldu_rsp_ready_o;

   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (vfu_acc && vfu_rsp_i.wb) begin
         push              = 1'b1;
         push_entry.id     = vfu_rsp_i.id;
         push_entry.rd     = vfu_rsp_i.rd;
         push_entry.result = vfu_rsp_i.result;
         push_entry.exc    = 1'b0;
      end else if (vlsu_acc && vlsu_rsp_i.exc) begin
         push           = 1'b1;
         push_entry.id  = vlsu_rsp_i.id;
         push_entry.exc = 1'b1;
      end
   end

   always_comb begin
      vreg_d = '0;
      id_d   = '0;
      if (vfu_acc) begin
         vreg_d[vfu_rsp_i.vd]  = 1'b1;
         vreg_d[vfu_rsp_i.vs1] = 1'b1;
         vreg_d[vfu_rsp_i.vs2] = 1'b1;
         id_d[vfu_rsp_i.id]    = 1'b1;
      end
      if (vlsu_acc) begin
         vreg_d[vlsu_rsp_i.vd] = 1'b1;
         id_d[vlsu_rsp_i.id]   = 1'b1;
      end
      if (vsldu_acc) begin
         vreg_d[vsldu_rsp_i.vd]  = 1'b1;
         vreg_d[vsldu_rsp_i.vs2] = 1'b1;
         id_d[vsldu_rsp_i.id]    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         retire_vreg_o <= '0;
         retire_id_o   <= '0;
         wptr          <= '0;
         rptr          <= '0;
         cnt           <= '0;
      end else begin
         retire_vreg_o <= vreg_d;
         retire_id_o   <= id_d;
         if (push) wptr <= (wptr == ptr_t'(NrWbEntries - 1)) ? '0 : wptr + 1'b1;
         if (pop)  rptr <= (rptr == ptr_t'(NrWbEntries - 1)) ? '0 : rptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: reads are gated by the occupancy counter.
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= push_entry;
   end

   assign head         = empty ? '0 : mem[rptr];
   assign rsp_valid_o  = !empty;
   assign rsp_id_o     = head.id;
   assign rsp_rd_o     = head.rd;
   assign rsp_result_o = head.result;
   assign rsp_exc_o    = head.exc;

endmodule

// File: tb/tb_spatz_retire_unit.sv
module tb_spatz_retire_unit;
   import spatz_retire_pkg::*;

   logic clk = 1'b0;
   logic rst_ni;
   logic vfu_v, vlsu_v, vsldu_v;
   vfu_rsp_t   vfu;
   vlsu_rsp_t  vlsu;
   vsldu_rsp_t vsldu;
   logic vfu_rdy, vlsu_rdy, vsldu_rdy;
   logic [NRVREG-1:0] retire_vreg;
   logic [31:0] retire_id;
   logic rsp_valid, rsp_ready;
   logic [4:0] rsp_id, rsp_rd;
   logic [ELEN-1:0] rsp_result;
   logic rsp_exc;

   spatz_retire_unit #(.NrWbEntries(2)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .vfu_rsp_valid_i(vfu_v), .vfu_rsp_i(vfu), .vfu_rsp_ready_o(vfu_rdy),
      .vlsu_rsp_valid_i(vlsu_v), .vlsu_rsp_i(vlsu), .vlsu_rsp_ready_o(vlsu_rdy),
      .vsldu_rsp_valid_i(vsldu_v), .vsldu_rsp_i(vsldu), .vsldu_rsp_ready_o(vsldu_rdy),
      .retire_vreg_o(retire_vreg), .retire_id_o(retire_id),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_rd_o(rsp_rd), .rsp_result_o(rsp_result), .rsp_exc_o(rsp_exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [31:0] vreg;
      logic [31:0] id;
   } ret_exp_t;

   ret_exp_t  ret_q[$];
   core_rsp_t core_q[$];
   int unsigned cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_ret(input logic [31:0] v, input logic [31:0] id);
      ret_exp_t e;
      e.cyc = cyc + 1; e.vreg = v; e.id = id;
      ret_q.push_back(e);
   endtask

   task automatic exp_core(input logic [4:0] id, input logic [4:0] rd, input logic [ELEN-1:0] res, input logic exc);
      core_rsp_t e;
      e.id = id; e.rd = rd; e.result = res; e.exc = exc;
      core_q.push_back(e);
   endtask

   function automatic vfu_rsp_t mk_vfu(input int unsigned id, input int unsigned vd, input int unsigned vs1,
                                       input int unsigned vs2, input logic wb, input int unsigned rd,
                                       input logic [ELEN-1:0] res);
      vfu_rsp_t r;
      r.id = instr_id_t'(id); r.vd = vreg_t'(vd); r.vs1 = vreg_t'(vs1); r.vs2 = vreg_t'(vs2);
      r.wb = wb; r.rd = 5'(rd); r.result = res;
      return r;
   endfunction

   task automatic set_idle();
      vfu_v = 1'b0; vfu = '0;
      vlsu_v = 1'b0; vlsu = '0;
      vsldu_v = 1'b0; vsldu = '0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_rd"}, rsp_rd, 0);
      chk({tag, "_rsp_result"}, rsp_result, 0);
      chk({tag, "_rsp_exc"}, rsp_exc, 0);
      chk({tag, "_retire_vreg"}, retire_vreg, 0);
      chk({tag, "_retire_id"}, retire_id, 0);
   endtask

   // Monitor: retire masks every cycle, core responses on each handshake.
   ret_exp_t  m_ret;
   core_rsp_t m_core;
   logic [31:0] m_vreg, m_id;
   always @(negedge clk) begin
      if (rst_ni) begin
         m_vreg = '0;
         m_id   = '0;
         if (ret_q.size() > 0 && ret_q[0].cyc == cyc) begin
            m_ret  = ret_q.pop_front();
            m_vreg = m_ret.vreg;
            m_id   = m_ret.id;
         end
         chk("retire_vreg", retire_vreg, m_vreg);
         chk("retire_id", retire_id, m_id);
         if (!rsp_valid) begin
            chk("idle_payload", {rsp_id, rsp_rd, rsp_result, rsp_exc}, 0);
         end else if (rsp_ready) begin
            if (core_q.size() == 0) begin
               chk("unexpected_core_rsp", 1, 0);
            end else begin
               m_core = core_q.pop_front();
               chk("core_id", rsp_id, m_core.id);
               chk("core_rd", rsp_rd, m_core.rd);
               chk("core_result", rsp_result, m_core.result);
               chk("core_exc", rsp_exc, m_core.exc);
            end
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      rsp_ready = 1'b0;
      set_idle();
      #1;
      chk_outputs_zero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      next_cyc();

      // Retire-only VFU response
      vfu_v = 1'b1; vfu = mk_vfu(3, 4, 5, 6, 1'b0, 0, '0);
      exp_ret(32'h70, 32'h8);
      @(negedge clk); chk("s1_vfu_ready", vfu_rdy, 1);
      next_cyc(); set_idle();
      @(negedge clk); chk("s1_no_rsp", rsp_valid, 0);
      next_cyc();

      // Writeback VFU held at head while core not ready
      vfu_v = 1'b1; vfu = mk_vfu(7, 2, 2, 2, 1'b1, 10, 32'hDEADBEEF);
      exp_ret(32'h4, 32'h80);
      exp_core(7, 10, 32'hDEADBEEF, 1'b0);
      @(negedge clk); chk("s2_vfu_ready", vfu_rdy, 1);
      next_cyc(); set_idle();
      repeat (3) begin
         @(negedge clk);
         chk("s2_held_valid", rsp_valid, 1);
         chk("s2_held_id", rsp_id, 7);
         next_cyc();
      end
      rsp_ready = 1'b1;
      @(negedge clk); next_cyc();
      rsp_ready = 1'b0;
      @(negedge clk); chk("s2_drained", rsp_valid, 0);
      next_cyc();

      // VFU priority over VLSU
      vfu_v = 1'b1; vfu = mk_vfu(1, 3, 3, 3, 1'b1, 5, 32'h11);
      vlsu_v = 1'b1; vlsu.id = 5'd2; vlsu.vd = 5'd8; vlsu.exc = 1'b1;
      exp_ret(32'h8, 32'h2);
      exp_core(1, 5, 32'h11, 1'b0);
      @(negedge clk);
      chk("s3_vfu_ready", vfu_rdy, 1);
      chk("s3_vlsu_blocked", vlsu_rdy, 0);
      next_cyc();
      vfu_v = 1'b0; vfu = '0;
      exp_ret(32'h100, 32'h4);
      exp_core(2, 0, '0, 1'b1);
      @(negedge clk); chk("s3_vlsu_ready", vlsu_rdy, 1);
      next_cyc(); set_idle();
      rsp_ready = 1'b1;
      repeat (2) begin @(negedge clk); next_cyc(); end
      rsp_ready = 1'b0;
      @(negedge clk); chk("s3_drained", rsp_valid, 0);
      next_cyc();

      // Fill, back-pressure, then sustained push+pop across wrap
      for (int i = 0; i < 2; i++) begin
         vfu_v = 1'b1; vfu = mk_vfu(10 + i, i, i, i, 1'b1, i, 32'h100 + i);
         exp_ret(32'(1) << i, 32'(1) << (10 + i));
         exp_core(5'(10 + i), 5'(i), 32'h100 + i, 1'b0);
         @(negedge clk); chk("s4_fill_ready", vfu_rdy, 1);
         next_cyc();
      end
      vfu = mk_vfu(12, 2, 2, 2, 1'b1, 2, 32'h102);
      @(negedge clk); chk("s4_full_ready", vfu_rdy, 0);
      next_cyc();
      rsp_ready = 1'b1;
      for (int i = 2; i < 10; i++) begin
         vfu_v = 1'b1; vfu = mk_vfu(10 + i, i, i, i, 1'b1, i, 32'h100 + i);
         exp_ret(32'(1) << i, 32'(1) << (10 + i));
         exp_core(5'(10 + i), 5'(i), 32'h100 + i, 1'b0);
         @(negedge clk);
         chk("s4_stream_ready", vfu_rdy, 1);
         chk("s4_stream_valid", rsp_valid, 1);
         next_cyc();
      end
      set_idle();
      repeat (2) begin @(negedge clk); next_cyc(); end
      rsp_ready = 1'b0;
      @(negedge clk); chk("s4_drained", rsp_valid, 0);
      next_cyc();

      // VSLDU and retire-only VLSU together, shared ID
      vsldu_v = 1'b1; vsldu.id = 5'd4; vsldu.vd = 5'd9; vsldu.vs2 = 5'd9;
      vlsu_v = 1'b1; vlsu.id = 5'd4; vlsu.vd = 5'd1; vlsu.exc = 1'b0;
      exp_ret(32'h202, 32'h10);
      @(negedge clk);
      chk("s5_vsldu_ready", vsldu_rdy, 1);
      chk("s5_vlsu_ready", vlsu_rdy, 1);
      next_cyc(); set_idle();
      @(negedge clk); next_cyc();

      // Reset mid-operation
      for (int i = 0; i < 2; i++) begin
         vfu_v = 1'b1; vfu = mk_vfu(20 + i, 20 + i, 20 + i, 20 + i, 1'b1, 1, 32'hA0 + i);
         exp_ret(32'(1) << (20 + i), 32'(1) << (20 + i));
         exp_core(5'(20 + i), 5'd1, 32'hA0 + i, 1'b0);
         next_cyc();
      end
      set_idle();
      chk("s6_pre_valid", rsp_valid, 1);
      chk("s6_pre_vreg", retire_vreg, 32'(1) << 21);
      #2;
      rst_ni = 1'b0;
      ret_q.delete();
      core_q.delete();
      #1;
      chk_outputs_zero("midreset");
      repeat (2) @(posedge clk);
      #2;
      rst_ni = 1'b1;
      next_cyc();
      @(negedge clk); chk("s6_empty_after", rsp_valid, 0);
      next_cyc();
      vfu_v = 1'b1; vfu = mk_vfu(22, 6, 6, 6, 1'b1, 3, 32'h55);
      exp_ret(32'h40, 32'(1) << 22);
      exp_core(22, 3, 32'h55, 1'b0);
      @(negedge clk); chk("s6_ready", vfu_rdy, 1);
      next_cyc(); set_idle();
      @(negedge clk); chk("s6_valid", rsp_valid, 1);
      next_cyc();
      rsp_ready = 1'b1;

      // Bounded drain of outstanding expectations
      for (int k = 0; k < 20; k++) begin
         if (core_q.size() == 0 && ret_q.size() == 0) break;
         @(negedge clk); next_cyc();
      end
      rsp_ready = 1'b0;
      chk("drain_core_q", 64'(core_q.size()), 0);
      chk("drain_ret_q", 64'(ret_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
